// File: rtl/fp16_recip.sv
// FP16 reciprocal for the softmax SFU: 11-step restoring divider producing 1/x
// with truncation, special-case handling and a fixed 12-cycle latency.
module fp16_recip (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        busy,
  output logic [15:0] out,
  output logic        valid
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [11:0] r_rem;
  logic [10:0] r_quo;
  logic [10:0] r_div;
  logic        r_sign;
  logic [4:0]  r_exp;
  logic [9:0]  r_man;
  logic [15:0] r_out;
  logic        r_valid;
  logic        r_busy;

  logic [12:0] w_diff;
  logic        w_ge;

  // Builds the final word; the quotient only matters for normal, non-power-of-two inputs.
  function automatic logic [15:0] assemble(input logic        s,
                                           input logic [4:0]  e,
                                           input logic [9:0]  m,
                                           input logic [10:0] q);
    logic signed [6:0] bexp;
    logic [15:0]       res;
    bexp = '0;
    res  = '0;
    if (e == 5'd0) begin
      res = {s, 5'h1F, 10'h000};
    end else if (e == 5'h1F) begin
      res = (m == 10'd0) ? {s, 15'h0000} : 16'h7E00;
    end else begin
      if (m == 10'd0) bexp = 7'sd30 - $signed({2'b00, e});
      else            bexp = 7'sd29 - $signed({2'b00, e});
      if (bexp <= 7'sd0) res = {s, 15'h0000};
      else               res = {s, bexp[4:0], (m == 10'd0) ? 10'h000 : q[9:0]};
    end
    return res;
  endfunction

  assign w_diff = {1'b0, r_rem} - {2'b00, r_div};
  assign w_ge   = ~w_diff[12];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_man   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy is still high in the valid cycle; it drops here unless a new operand arrives
          r_busy <= in_valid;
          if (in_valid) begin
            r_sign  <= in_data[15];
            r_exp   <= in_data[14:10];
            r_man   <= in_data[9:0];
            r_div   <= {1'b1, in_data[9:0]};
            r_rem   <= 12'd2048;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_quo <= {r_quo[9:0], w_ge};
          r_rem <= w_ge ? {w_diff[10:0], 1'b0} : {r_rem[10:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd10) r_state <= S_DONE;
        end
        S_DONE: begin
          r_out   <= assemble(r_sign, r_exp, r_man, r_quo);
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out   = r_out;
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule

// File: tb/tb_fp16_recip.sv
// Directed and randomised checks of fp16_recip against hand-computed reciprocals.
module tb_fp16_recip;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        busy;
  logic [15:0] out;
  logic        valid;

  int errors = 0;
  int checks = 0;

  fp16_recip dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .out(out), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accepts one operand, waits (bounded) for valid, checks latency, result and the pulse end.
  task automatic do_op(input string tag, input logic [15:0] din, input logic [15:0] exp);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 16'hxxxx;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (valid) break;
    end
    chk({tag, "_lat"}, k, 12);
    chk({tag, "_out"}, out, exp);
    @(posedge clk);
    #1;
    chk({tag, "_vpulse"}, valid, 1'b0);
    chk({tag, "_busy_off"}, busy, 1'b0);
  endtask

  function automatic logic [15:0] model(input logic [15:0] x);
    int e, m, q, be;
    e = x[14:10];
    m = x[9:0];
    q = (1 << 21) / (1024 + m);
    be = (m == 0) ? 30 - e : 29 - e;
    if (be <= 0) return {x[15], 15'h0};
    return {x[15], be[4:0], (m == 0) ? 10'h000 : q[9:0]};
  endfunction

  initial begin
    int vcnt, bcnt;
    logic [15:0] vout, r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out", out, 16'h0000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);

    do_op("two",     16'h4000, 16'h3800);
    do_op("one",     16'h3C00, 16'h3C00);
    do_op("mtwo",    16'hC000, 16'hB800);
    do_op("three",   16'h4200, 16'h3555);
    do_op("sum72",   16'h5480, 16'h231C);
    do_op("zero",    16'h0000, 16'h7C00);
    do_op("mzero",   16'h8000, 16'hFC00);
    do_op("inf",     16'h7C00, 16'h0000);
    do_op("minf",    16'hFC00, 16'h8000);
    do_op("nan",     16'h7E01, 16'h7E00);
    do_op("mnan",    16'hFE00, 16'h7E00);
    do_op("uflow30", 16'h7800, 16'h0000);
    do_op("uflow29", 16'hF401, 16'h8000);
    do_op("minnorm", 16'h7400, 16'h0400);
    do_op("subn",    16'h0001, 16'h7C00);

    // Busy drop: extra strobes at edges 5 and 12 must be ignored
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h4000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    vcnt = 0;
    bcnt = 0;
    vout = 16'h0000;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      in_valid = (e == 5 || e == 12);
      in_data  = 16'h4200;
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (valid) begin
        vcnt++;
        vout = out;
      end
      if (busy) bcnt++;
    end
    chk("drop_vcnt", vcnt, 1);
    chk("drop_out", vout, 16'h3800);
    chk("drop_busy", bcnt, 12);
    do_op("edge13", 16'h4200, 16'h3555);

    // Reset at edge 6 of an operation discards it
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h4200;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_out", out, 16'h0000);
    chk("mid_rst_busy", busy, 1'b0);
    vcnt = 0;
    for (int e = 0; e < 14; e++) begin
      @(posedge clk);
      #1;
      if (valid) vcnt++;
    end
    chk("mid_rst_novalid", vcnt, 0);
    chk("mid_rst_hold", out, 16'h0000);
    do_op("after_rst", 16'h4000, 16'h3800);

    // Random normal operands against a truncating-division model
    for (int i = 0; i < 64; i++) begin
      r = 16'($urandom);
      r[14:10] = 5'($urandom_range(1, 30));
      do_op("rand", r, model(r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
